// File: rtl/egr_prc_seg_gen.sv
// rtl/egr_prc_seg_gen.sv - PRC front-end: expands PFS fetch requests into credit-gated per-segment reads
// One request becomes nseg read beats (nseg=0 treated as 1); the next request may be taken on the eop beat.
module egr_prc_seg_gen #(
   parameter int PTR_W   = 16,
   parameter int SEG_W   = 6,
   parameter int PORT_W  = 5,
   parameter int CREDITS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pfs_req_valid,
   output logic              pfs_req_ready,
   input  logic [PTR_W-1:0]  pfs_req_ptr,
   input  logic [SEG_W-1:0]  pfs_req_nseg,
   input  logic [PORT_W-1:0] pfs_req_port,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [PTR_W-1:0]  rd_addr,
   output logic [PORT_W-1:0] rd_port,
   output logic              rd_sop,
   output logic              rd_eop,
   input  logic              rd_credit_ret,
   output logic [7:0]        credits,
   output logic              busy,
   output logic              err_zero_len,
   output logic              err_credit_ovf
);

   typedef enum logic [0:0] {S_IDLE, S_ISSUE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PTR_W-1:0]  r_ptr;
   logic [PORT_W-1:0] r_port;
   logic [SEG_W-1:0]  r_rem;
   logic              r_sop;
   logic              r_valid;
   logic [7:0]        r_credits;
   logic [7:0]        w_credits_nxt;
   logic              r_err_zero;
   logic              r_err_ovf;
   logic              w_eop;
   logic              w_hs;
   logic              w_last;
   logic              w_acc;
   logic              w_ovf;
   logic              w_zero;

   assign w_eop  = (r_rem == SEG_W'(1));
   assign w_hs   = r_valid & rd_ready;
   assign w_last = w_hs & w_eop;
   assign w_zero = (pfs_req_nseg == '0);

   // Ready on the eop handshake lets a held request chain in with no bubble.
   assign pfs_req_ready = (r_state == S_IDLE) | w_last;
   assign w_acc         = pfs_req_valid & pfs_req_ready;
   assign w_ovf         = rd_credit_ret & ~w_hs & (r_credits == 8'(CREDITS));

   always_comb begin
      w_credits_nxt = r_credits;
      if (w_hs && !rd_credit_ret)
         w_credits_nxt = r_credits - 8'd1;
      else if (!w_hs && rd_credit_ret && !w_ovf)
         w_credits_nxt = r_credits + 8'd1;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_acc) w_state_nxt = S_ISSUE;
         S_ISSUE: if (w_last && !pfs_req_valid) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr      <= '0;
         r_port     <= '0;
         r_rem      <= '0;
         r_sop      <= 1'b0;
         r_valid    <= 1'b0;
         r_credits  <= 8'(CREDITS);
         r_err_zero <= 1'b0;
         r_err_ovf  <= 1'b0;
      end else begin
         if (w_acc) begin
            r_ptr  <= pfs_req_ptr;
            r_port <= pfs_req_port;
            r_rem  <= w_zero ? SEG_W'(1) : pfs_req_nseg;
            r_sop  <= 1'b1;
         end else if (w_hs) begin
            r_ptr  <= r_ptr + PTR_W'(1);
            r_rem  <= r_rem - SEG_W'(1);
            r_sop  <= 1'b0;
         end
         // Credits only drop through our own handshake, so a pending valid never retracts.
         r_valid    <= (w_state_nxt == S_ISSUE) && (w_credits_nxt != 8'd0);
         r_credits  <= w_credits_nxt;
         r_err_zero <= w_acc & w_zero;
         r_err_ovf  <= w_ovf;
      end
   end

   assign rd_valid       = r_valid;
   assign rd_addr        = r_ptr;
   assign rd_port        = r_port;
   assign rd_sop         = r_sop;
   assign rd_eop         = w_eop;
   assign credits        = r_credits;
   assign busy           = (r_state == S_ISSUE);
   assign err_zero_len   = r_err_zero;
   assign err_credit_ovf = r_err_ovf;

endmodule

// File: tb/tb_egr_prc_seg_gen.sv
// tb/tb_egr_prc_seg_gen.sv - directed bench for egr_prc_seg_gen
// Main instance uses CREDITS=8; a second instance with CREDITS=2 exercises credit stalls.
module tb_egr_prc_seg_gen;

   logic        clk;
   logic        rst_n;
   logic        pfs_req_valid;
   logic        pfs_req_ready;
   logic [15:0] pfs_req_ptr;
   logic [5:0]  pfs_req_nseg;
   logic [4:0]  pfs_req_port;
   logic        rd_valid;
   logic        rd_ready;
   logic [15:0] rd_addr;
   logic [4:0]  rd_port;
   logic        rd_sop;
   logic        rd_eop;
   logic        rd_credit_ret;
   logic [7:0]  credits;
   logic        busy;
   logic        err_zero_len;
   logic        err_credit_ovf;

   logic        d2_req_valid;
   logic        d2_req_ready;
   logic [15:0] d2_req_ptr;
   logic [5:0]  d2_req_nseg;
   logic [4:0]  d2_req_port;
   logic        d2_rd_valid;
   logic        d2_rd_ready;
   logic [15:0] d2_rd_addr;
   logic [4:0]  d2_rd_port;
   logic        d2_rd_sop;
   logic        d2_rd_eop;
   logic        d2_credit_ret;
   logic [7:0]  d2_credits;
   logic        d2_busy;
   logic        d2_err_zero;
   logic        d2_err_ovf;

   int          total;
   int          bad;
   int          cyc;
   int          min_cred;
   logic        ret_auto;
   logic [1:0]  ret_pipe;
   logic [15:0] cap_addr[$];
   logic        cap_sop[$];
   logic        cap_eop[$];
   logic [4:0]  cap_port[$];
   int          cap_cyc[$];

   egr_prc_seg_gen dut (
      .clk(clk), .rst_n(rst_n),
      .pfs_req_valid(pfs_req_valid), .pfs_req_ready(pfs_req_ready),
      .pfs_req_ptr(pfs_req_ptr), .pfs_req_nseg(pfs_req_nseg), .pfs_req_port(pfs_req_port),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_port(rd_port),
      .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_credit_ret(rd_credit_ret), .credits(credits),
      .busy(busy), .err_zero_len(err_zero_len), .err_credit_ovf(err_credit_ovf)
   );

   egr_prc_seg_gen #(.CREDITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .pfs_req_valid(d2_req_valid), .pfs_req_ready(d2_req_ready),
      .pfs_req_ptr(d2_req_ptr), .pfs_req_nseg(d2_req_nseg), .pfs_req_port(d2_req_port),
      .rd_valid(d2_rd_valid), .rd_ready(d2_rd_ready), .rd_addr(d2_rd_addr), .rd_port(d2_rd_port),
      .rd_sop(d2_rd_sop), .rd_eop(d2_rd_eop), .rd_credit_ret(d2_credit_ret), .credits(d2_credits),
      .busy(d2_busy), .err_zero_len(d2_err_zero), .err_credit_ovf(d2_err_ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Record the beat about to be taken, drive delayed credit returns, then advance one cycle.
   task automatic step();
      if (rd_valid && rd_ready) begin
         cap_addr.push_back(rd_addr);
         cap_sop.push_back(rd_sop);
         cap_eop.push_back(rd_eop);
         cap_port.push_back(rd_port);
         cap_cyc.push_back(cyc);
      end
      if (ret_auto) begin
         rd_credit_ret = ret_pipe[1];
         ret_pipe = {ret_pipe[0], rd_valid && rd_ready};
      end
      if (int'(credits) < min_cred) min_cred = int'(credits);
      @(negedge clk);
      cyc++;
   endtask

   task automatic clear_caps();
      cap_addr.delete(); cap_sop.delete(); cap_eop.delete(); cap_port.delete(); cap_cyc.delete();
      min_cred = 255;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({rd_valid, rd_addr, rd_port, rd_sop, rd_eop, busy, err_zero_len, err_credit_ovf} !== 28'h0) begin
         bad++; $display("FAIL reset_outputs got=%h exp=0", {rd_valid, rd_addr, rd_port, rd_sop, rd_eop, busy, err_zero_len, err_credit_ovf});
      end
      total++;
      if (credits !== 8'd8 || d2_credits !== 8'd2) begin
         bad++; $display("FAIL reset_credits got=%0d/%0d exp=8/2", credits, d2_credits);
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (pfs_req_ready !== 1'b1) begin
         bad++; $display("FAIL reset_ready got=%b exp=1", pfs_req_ready);
      end
   endtask

   task automatic test_single();
      logic [15:0] ea [3];
      logic        es [3];
      logic        ee [3];
      ea = '{16'h0100, 16'h0101, 16'h0102};
      es = '{1'b1, 1'b0, 1'b0};
      ee = '{1'b0, 1'b0, 1'b1};
      clear_caps();
      @(negedge clk);
      rd_ready = 1'b1;
      pfs_req_valid = 1'b1; pfs_req_ptr = 16'h0100; pfs_req_nseg = 6'd3; pfs_req_port = 5'd4;
      step();
      pfs_req_valid = 1'b0;
      total++;
      if ({rd_valid, rd_sop, busy} !== 3'b111) begin
         bad++; $display("FAIL single_first_valid got=%b exp=111", {rd_valid, rd_sop, busy});
      end
      repeat (9) step();
      total++;
      if (cap_addr.size() != 3) begin
         bad++; $display("FAIL single_beat_count got=%0d exp=3", cap_addr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (cap_addr[i] !== ea[i] || cap_sop[i] !== es[i] || cap_eop[i] !== ee[i] || cap_port[i] !== 5'd4) begin
               bad++; $display("FAIL single_beat%0d got=%h/%b/%b/%0d exp=%h/%b/%b/4", i, cap_addr[i], cap_sop[i], cap_eop[i], cap_port[i], ea[i], es[i], ee[i]);
            end
         end
      end
      total++;
      if (min_cred != 6 || credits !== 8'd8 || busy !== 1'b0) begin
         bad++; $display("FAIL single_credits got=min%0d/end%0d/busy%b exp=min6/end8/busy0", min_cred, credits, busy);
      end
   endtask

   task automatic test_back_to_back();
      clear_caps();
      pfs_req_valid = 1'b1; pfs_req_ptr = 16'h0200; pfs_req_nseg = 6'd2; pfs_req_port = 5'd1;
      step();
      pfs_req_ptr = 16'h0300; pfs_req_nseg = 6'd1; pfs_req_port = 5'd2;
      #1;
      total++;
      if (pfs_req_ready !== 1'b0) begin
         bad++; $display("FAIL b2b_ready_mid got=%b exp=0", pfs_req_ready);
      end
      step();
      #1;
      total++;
      if (pfs_req_ready !== 1'b1 || rd_eop !== 1'b1) begin
         bad++; $display("FAIL b2b_ready_eop got=%b/%b exp=1/1", pfs_req_ready, rd_eop);
      end
      step();
      pfs_req_valid = 1'b0;
      repeat (6) step();
      total++;
      if (cap_addr.size() != 3) begin
         bad++; $display("FAIL b2b_beat_count got=%0d exp=3", cap_addr.size());
      end else begin
         total++;
         if ({cap_addr[0], cap_addr[1], cap_addr[2]} !== {16'h0200, 16'h0201, 16'h0300}) begin
            bad++; $display("FAIL b2b_addr got=%h %h %h exp=0200 0201 0300", cap_addr[0], cap_addr[1], cap_addr[2]);
         end
         total++;
         if ({cap_sop[0], cap_sop[1], cap_sop[2], cap_eop[0], cap_eop[1], cap_eop[2]} !== 6'b101011) begin
            bad++; $display("FAIL b2b_flags got=%b exp=101011", {cap_sop[0], cap_sop[1], cap_sop[2], cap_eop[0], cap_eop[1], cap_eop[2]});
         end
         total++;
         if (cap_cyc[2] - cap_cyc[0] != 2 || cap_port[2] !== 5'd2) begin
            bad++; $display("FAIL b2b_no_bubble got=span%0d/port%0d exp=span2/port2", cap_cyc[2] - cap_cyc[0], cap_port[2]);
         end
      end
   endtask

   task automatic test_credit_stall();
      int          cnt;
      logic [15:0] last_addr;
      cnt = 0;
      last_addr = 16'h0;
      d2_rd_ready = 1'b1;
      d2_req_valid = 1'b1; d2_req_ptr = 16'h0010; d2_req_nseg = 6'd4; d2_req_port = 5'd3;
      step();
      d2_req_valid = 1'b0;
      repeat (6) begin
         if (d2_rd_valid && d2_rd_ready) cnt++;
         step();
      end
      total++;
      if (cnt != 2 || d2_rd_valid !== 1'b0 || d2_credits !== 8'd0 || d2_busy !== 1'b1) begin
         bad++; $display("FAIL stall_first got=beats%0d/v%b/c%0d/b%b exp=beats2/v0/c0/b1", cnt, d2_rd_valid, d2_credits, d2_busy);
      end
      d2_credit_ret = 1'b1;
      step();
      d2_credit_ret = 1'b0;
      total++;
      if (d2_rd_valid !== 1'b1 || d2_credits !== 8'd1) begin
         bad++; $display("FAIL stall_reassert got=v%b/c%0d exp=v1/c1", d2_rd_valid, d2_credits);
      end
      repeat (6) begin
         if (d2_rd_valid && d2_rd_ready) begin
            cnt++;
            last_addr = d2_rd_addr;
         end
         step();
      end
      total++;
      if (cnt != 3 || last_addr !== 16'h0012 || d2_rd_valid !== 1'b0 || d2_credits !== 8'd0) begin
         bad++; $display("FAIL stall_second got=beats%0d/a%h/v%b/c%0d exp=beats3/a0012/v0/c0", cnt, last_addr, d2_rd_valid, d2_credits);
      end
   endtask

   task automatic test_wrap();
      logic        prev_pend;
      logic [26:0] prev_f;
      clear_caps();
      prev_pend = 1'b0;
      prev_f = '0;
      rd_ready = 1'b1;
      pfs_req_valid = 1'b1; pfs_req_ptr = 16'hFFFE; pfs_req_nseg = 6'd3; pfs_req_port = 5'd7;
      step();
      pfs_req_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (prev_pend) begin
            total++;
            if ({rd_valid, rd_addr, rd_port, rd_sop, rd_eop} !== prev_f) begin
               bad++; $display("FAIL wrap_stable%0d got=%h exp=%h", i, {rd_valid, rd_addr, rd_port, rd_sop, rd_eop}, prev_f);
            end
         end
         rd_ready = (i % 2 == 1);
         prev_pend = rd_valid && !rd_ready;
         prev_f = {rd_valid, rd_addr, rd_port, rd_sop, rd_eop};
         step();
      end
      rd_ready = 1'b1;
      total++;
      if (cap_addr.size() != 3) begin
         bad++; $display("FAIL wrap_beat_count got=%0d exp=3", cap_addr.size());
      end else begin
         total++;
         if ({cap_addr[0], cap_addr[1], cap_addr[2]} !== {16'hFFFE, 16'hFFFF, 16'h0000} ||
             {cap_sop[0], cap_eop[2], cap_port[1]} !== {1'b1, 1'b1, 5'd7}) begin
            bad++; $display("FAIL wrap_addr got=%h %h %h exp=fffe ffff 0000", cap_addr[0], cap_addr[1], cap_addr[2]);
         end
      end
   endtask

   task automatic test_zero_len_ovf();
      clear_caps();
      pfs_req_valid = 1'b1; pfs_req_ptr = 16'h0050; pfs_req_nseg = 6'd0; pfs_req_port = 5'd9;
      step();
      pfs_req_valid = 1'b0;
      total++;
      if (err_zero_len !== 1'b1) begin
         bad++; $display("FAIL zero_len_pulse got=%b exp=1", err_zero_len);
      end
      step();
      total++;
      if (err_zero_len !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL zero_len_clear got=%b/%b exp=0/0", err_zero_len, busy);
      end
      repeat (5) step();
      total++;
      if (cap_addr.size() != 1) begin
         bad++; $display("FAIL zero_len_count got=%0d exp=1", cap_addr.size());
      end else begin
         total++;
         if (cap_addr[0] !== 16'h0050 || cap_sop[0] !== 1'b1 || cap_eop[0] !== 1'b1) begin
            bad++; $display("FAIL zero_len_beat got=%h/%b/%b exp=0050/1/1", cap_addr[0], cap_sop[0], cap_eop[0]);
         end
      end
      ret_auto = 1'b0;
      rd_credit_ret = 1'b1;
      total++;
      if (credits !== 8'd8) begin
         bad++; $display("FAIL ovf_pre_credits got=%0d exp=8", credits);
      end
      step();
      rd_credit_ret = 1'b0;
      total++;
      if (err_credit_ovf !== 1'b1 || credits !== 8'd8) begin
         bad++; $display("FAIL ovf_pulse got=%b/%0d exp=1/8", err_credit_ovf, credits);
      end
      step();
      total++;
      if (err_credit_ovf !== 1'b0 || credits !== 8'd8) begin
         bad++; $display("FAIL ovf_clear got=%b/%0d exp=0/8", err_credit_ovf, credits);
      end
      ret_auto = 1'b1;
      ret_pipe = 2'b00;
   endtask

   task automatic test_reset_mid();
      clear_caps();
      pfs_req_valid = 1'b1; pfs_req_ptr = 16'h0400; pfs_req_nseg = 6'd4; pfs_req_port = 5'd5;
      step();
      pfs_req_valid = 1'b0;
      step();
      #2;
      rst_n = 1'b0;
      ret_pipe = 2'b00;
      rd_credit_ret = 1'b0;
      #1;
      total++;
      if ({rd_valid, rd_addr, rd_port, rd_sop, rd_eop, busy} !== 26'h0 || credits !== 8'd8) begin
         bad++; $display("FAIL rstmid_async got=%h/%0d exp=0/8", {rd_valid, rd_addr, rd_port, rd_sop, rd_eop, busy}, credits);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (credits !== 8'd8 || busy !== 1'b0 || pfs_req_ready !== 1'b1) begin
         bad++; $display("FAIL rstmid_after got=c%0d/b%b/r%b exp=c8/b0/r1", credits, busy, pfs_req_ready);
      end
      clear_caps();
      pfs_req_valid = 1'b1; pfs_req_ptr = 16'h0500; pfs_req_nseg = 6'd2; pfs_req_port = 5'd6;
      step();
      pfs_req_valid = 1'b0;
      repeat (6) step();
      total++;
      if (cap_addr.size() != 2) begin
         bad++; $display("FAIL rstmid_count got=%0d exp=2", cap_addr.size());
      end else begin
         total++;
         if ({cap_addr[0], cap_sop[0], cap_eop[0], cap_addr[1], cap_sop[1], cap_eop[1]} !== {16'h0500, 2'b10, 16'h0501, 2'b01}) begin
            bad++; $display("FAIL rstmid_beats got=%h/%b%b %h/%b%b exp=0500/10 0501/01", cap_addr[0], cap_sop[0], cap_eop[0], cap_addr[1], cap_sop[1], cap_eop[1]);
         end
      end
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; min_cred = 255;
      ret_auto = 1'b1; ret_pipe = 2'b00;
      rst_n = 1'b0;
      pfs_req_valid = 1'b0; pfs_req_ptr = '0; pfs_req_nseg = '0; pfs_req_port = '0;
      rd_ready = 1'b0; rd_credit_ret = 1'b0;
      d2_req_valid = 1'b0; d2_req_ptr = '0; d2_req_nseg = '0; d2_req_port = '0;
      d2_rd_ready = 1'b0; d2_credit_ret = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_credit_stall();
      test_wrap();
      test_zero_len_ovf();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/egr_prc_seg_gen.md
Name: egr_prc_seg_gen

Overview:
- Front-end of the Packet Read Controller (PRC), directly downstream of the Packet Fetch Scheduler (PFS) in the EGR partition.
- Accepts one packet-fetch request per packet from PFS: start segment pointer, segment count, destination port.
- Expands each request into a stream of per-segment read requests toward packet memory, marked with SOP/EOP.
- Flow-controls that stream with a read-credit counter.

Parameters:
- PTR_W, 16, segment pointer width; pointers wrap modulo 2^PTR_W.
- SEG_W, 6, segment count width (1..2^SEG_W-1 segments per packet).
- PORT_W, 5, destination port id width.
- CREDITS, 8, outstanding memory-read credits after reset (>=1, <=255).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- pfs_req_valid  input  1  PFS fetch request valid.
- pfs_req_ready  output  1  block accepts request this cycle.
- pfs_req_ptr  input  PTR_W  first segment pointer.
- pfs_req_nseg  input  SEG_W  number of segments in packet.
- pfs_req_port  input  PORT_W  destination port.
- rd_valid  output  1  segment read request valid.
- rd_ready  input  1  memory side accepts read.
- rd_addr  output  PTR_W  segment pointer to read.
- rd_port  output  PORT_W  port tag for the read.
- rd_sop  output  1  first segment of packet.
- rd_eop  output  1  last segment of packet.
- rd_credit_ret  input  1  one credit returned (pulse per cycle).
- credits  output  8  current credit count.
- busy  output  1  packet in progress.
- err_zero_len  output  1  one-cycle pulse: request with nseg=0 accepted.
- err_credit_ovf  output  1  one-cycle pulse: credit returned while count==CREDITS.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - State IDLE.
  - credits=CREDITS.
  - rd_valid=0, rd_addr=0, rd_port=0, rd_sop=0, rd_eop=0.
  - busy=0, err pulses=0.
  - pfs_req_ready=1 in the first cycle after reset.
- States: IDLE, ISSUE.
- IDLE:
  - pfs_req_ready=1.
  - On pfs_req_valid: latch ptr/port, remaining count = nseg; set sop flag; move to ISSUE.
- Request handshake at cycle N -> rd_valid may first assert at N+1 (all rd_* outputs registered).
- Zero-length request: nseg=0 is processed as nseg=1; err_zero_len pulses in cycle N+1.
- ISSUE:
  - rd_valid=1 whenever credits>0.
  - rd_addr = current pointer; rd_sop = first beat; rd_eop = remaining==1.
  - Once rd_valid is asserted, it and all rd_* fields stay stable until rd_ready. A credit cannot disappear while valid is pending, because only this block's own handshake consumes credits.
- Beat handshake (rd_valid & rd_ready):
  - pointer+1 modulo 2^PTR_W (0xFFFF -> 0x0000 for PTR_W=16).
  - remaining-1; sop cleared.
- Last beat (eop handshake):
  - If pfs_req_valid is high in the same cycle, pfs_req_ready=1 (combinational on rd_ready & rd_eop & rd_valid). The new request is latched and the state stays ISSUE with no bubble.
  - Otherwise return to IDLE.
- pfs_req_ready=0 in ISSUE except on the last-beat handshake.
- Credit counter:
  - -1 on beat handshake, +1 on rd_credit_ret; both in the same cycle -> unchanged.
  - Return with credits==CREDITS and no handshake: saturate, and pulse err_credit_ovf.
  - credits==0 -> rd_valid=0 (stall) until a return arrives. rd_valid reasserts the cycle after the return.
- busy=1 in ISSUE.
- Reset mid-packet: remaining segments are discarded, credits restored to CREDITS, no partial state retained.

Test Plan:
- Single request ptr=0x0100, nseg=3, port=4, rd_ready=1, credits returned 2 cycles after each read -> reads 0x0100(sop), 0x0101, 0x0102(eop), port=4 each. First rd_valid 1 cycle after accept. credits dips to 6 and recovers to 8.
- Back-to-back requests (nseg=2 then nseg=1), pfs_req_valid held -> second accepted on the eop handshake cycle; 3 consecutive beats with no bubble; sop on beats 1 and 3.
- CREDITS=2, no returns, nseg=4 -> 2 beats, then rd_valid=0 with credits=0, busy=1. One rd_credit_ret pulse -> exactly one more beat, then stall again.
- ptr=0xFFFE, nseg=3, with rd_ready toggling 1/0 -> addresses 0xFFFE, 0xFFFF, 0x0000. Fields stable while rd_ready=0.
- nseg=0 request -> one beat with sop=eop=1 and an err_zero_len pulse. Credit return at credits=8 with no read -> err_credit_ovf pulse, credits stays 8.
- Assert rst_n=0 mid-packet (after beat 1 of 4) -> outputs immediately at reset values; after release, credits=8 and state IDLE; the next request is processed from sop.
